// File: rtl/branch_pkg.sv
// Shared definitions for the branch/jump resolution unit: instruction IDs,
// default datapath width and the branch-kind classification.
package branch_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam int ID_BEQ  = 15;
    localparam int ID_BNE  = 16;
    localparam int ID_BGT  = 17;
    localparam int ID_BGTE = 18;
    localparam int ID_BLE  = 19;
    localparam int ID_BLEQ = 20;
    localparam int ID_J    = 21;
    localparam int ID_JR   = 22;
    localparam int ID_JAL  = 23;

    // Number of consecutive IDs handled, starting at the base ID
    localparam int ID_COUNT = 9;

    typedef enum logic [2:0] {
        EQ,
        NE,
        GT,
        GE,
        LT,
        LE,
        JUMP,
        NONE
    } branch_kind_e;

    // Maps an offset from the base ID to the kind of control-flow change
    function automatic branch_kind_e kind_from_offset(input logic [3:0] offset);
        branch_kind_e kind;
        case (offset)
            4'd0:    kind = EQ;
            4'd1:    kind = NE;
            4'd2:    kind = GT;
            4'd3:    kind = GE;
            4'd4:    kind = LT;
            4'd5:    kind = LE;
            4'd6,
            4'd7,
            4'd8:    kind = JUMP;
            default: kind = NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Signed two's-complement comparator producing equal / less / greater flags.
module branch_compare
    import branch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Flags are derived from a signed interpretation of both operands
    always_comb begin
        eq = (rs == rt);
        lt = ($signed(rs) < $signed(rt));
        gt = ($signed(rs) > $signed(rt));
    end

endmodule

// File: rtl/branch_top.sv
// Branch/jump resolution for the execute stage: decodes the instruction ID,
// selects the branch offset or jump target, and keeps a sticky flag for
// unsupported IDs.
module branch_top
    import branch_pkg::*;
#(
    parameter int WIDTH  = branch_pkg::DEFAULT_WIDTH,
    parameter int ID_BEQ = branch_pkg::ID_BEQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] ID,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] out,
    output logic             warn_signal
);

    localparam logic [WIDTH-1:0] ID_BASE  = WIDTH'(ID_BEQ);
    localparam logic [WIDTH-1:0] ID_LAST  = WIDTH'(ID_COUNT - 1);

    logic [WIDTH-1:0] id_offset;
    logic             id_valid;
    branch_kind_e     kind;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             taken;

    // pc_in and ir travel with the instruction but never influence the result
    logic unused_inputs;
    assign unused_inputs = ^{pc_in, ir};

    branch_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .rs (rs),
        .rt (rt),
        .eq (eq),
        .lt (lt),
        .gt (gt)
    );

    // Decode the ID into a branch kind; anything outside the handled range is NONE
    always_comb begin
        id_offset = ID - ID_BASE;
        id_valid  = (ID >= ID_BASE) && (id_offset <= ID_LAST);
        kind      = NONE;
        if (id_valid) begin
            kind = kind_from_offset(id_offset[3:0]);
        end
    end

    // Resolve the branch condition and select offset, target or zero
    always_comb begin
        taken = 1'b0;
        out   = '0;
        case (kind)
            EQ:      taken = eq;
            NE:      taken = !eq;
            GT:      taken = gt;
            GE:      taken = !lt;
            LT:      taken = lt;
            LE:      taken = !gt;
            default: taken = 1'b0;
        endcase
        if (!reset) begin
            if (kind == JUMP) begin
                out = rs;
            end else if (taken) begin
                out = rd;
            end
        end
    end

    // Sticky unsupported-ID flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warn_signal <= 1'b0;
        end else if (!id_valid) begin
            warn_signal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_top.sv
// Directed self-checking bench for branch_top.
module tb_branch_top;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] ir;
    logic [31:0] ID;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [31:0] out;
    logic        warn_signal;

    int checkCount = 0;
    int errorCount = 0;

    branch_top dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .ir          (ir),
        .ID          (ID),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .out         (out),
        .warn_signal (warn_signal)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [31:0] id, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] off);
        ID = id;
        rs = a;
        rt = b;
        rd = off;
        pc_in = pc_in + 32'd4;
        ir = {6'h04, 26'h155AA};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b0;
        pc_in = 32'h0000_1000;
        ir    = '0;
        ID    = 32'd15;
        rs    = 32'd10;
        rt    = 32'd12;
        rd    = 32'd1;

        #1 reset = 1'b1;
        #0.5;
        checkOutput("reset_out", out, 32'd0);
        checkOutput("reset_warn", {31'd0, warn_signal}, 32'd0);
        #0.5 reset = 1'b0;
        #1;
        checkOutput("post_reset_out", out, 32'd0);
        checkOutput("post_reset_warn", {31'd0, warn_signal}, 32'd0);

        // Equality branches
        applyStimulus(32'd15, 32'd10, 32'd12, 32'd1);
        checkOutput("beq_not_taken", out, 32'd0);
        applyStimulus(32'd16, 32'd10, 32'd12, 32'd2);
        checkOutput("bne_taken", out, 32'd2);
        applyStimulus(32'd16, 32'd7, 32'd7, 32'd2);
        checkOutput("bne_not_taken", out, 32'd0);
        applyStimulus(32'd15, 32'd7, 32'd7, 32'd5);
        checkOutput("beq_taken", out, 32'd5);
        applyStimulus(32'd15, 32'd7, 32'd7, 32'd0);
        checkOutput("beq_taken_rd0", out, 32'd0);

        // Greater-than family, signed
        applyStimulus(32'd17, 32'd10, 32'd10, 32'd99);
        checkOutput("bgt_equal", out, 32'd0);
        applyStimulus(32'd18, 32'd10, 32'd10, 32'd99);
        checkOutput("bgte_equal", out, 32'd99);
        applyStimulus(32'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd3);
        checkOutput("bgt_signed", out, 32'd3);
        applyStimulus(32'd18, 32'hFFFF_FFFB, 32'd1, 32'd8);
        checkOutput("bgte_neg_lt_pos", out, 32'd0);
        applyStimulus(32'd17, 32'h8000_0000, 32'h7FFF_FFFF, 32'd6);
        checkOutput("bgt_extreme", out, 32'd0);

        // Less-than family, signed
        applyStimulus(32'd19, 32'd10, 32'd10, 32'd99);
        checkOutput("ble_equal", out, 32'd0);
        applyStimulus(32'd20, 32'd10, 32'd10, 32'd99);
        checkOutput("bleq_equal", out, 32'd99);
        applyStimulus(32'd19, 32'h8000_0000, 32'h7FFF_FFFF, 32'd4);
        checkOutput("ble_extreme", out, 32'd4);
        applyStimulus(32'd20, 32'd11, 32'd10, 32'd7);
        checkOutput("bleq_greater", out, 32'd0);

        // Unconditional jumps pass rs through
        applyStimulus(32'd21, 32'd100, 32'd3, 32'd9);
        checkOutput("j", out, 32'd100);
        applyStimulus(32'd22, 32'd5, 32'd5, 32'd0);
        checkOutput("jr", out, 32'd5);
        applyStimulus(32'd23, 32'd100, 32'hDEAD_BEEF, 32'd77);
        checkOutput("jal", out, 32'd100);

        // No invalid ID has been seen at any edge yet
        @(posedge clk);
        #1;
        checkOutput("warn_clear_valid", {31'd0, warn_signal}, 32'd0);

        // Invalid ID held across exactly one rising edge
        @(negedge clk);
        applyStimulus(32'd40, 32'd5, 32'd5, 32'd5);
        checkOutput("invalid_out", out, 32'd0);
        checkOutput("invalid_warn_before_edge", {31'd0, warn_signal}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("invalid_warn_set", {31'd0, warn_signal}, 32'd1);
        applyStimulus(32'd14, 32'd5, 32'd5, 32'd5);
        checkOutput("id14_out", out, 32'd0);
        applyStimulus(32'd24, 32'd5, 32'd5, 32'd5);
        checkOutput("id24_out", out, 32'd0);
        applyStimulus(32'd21, 32'd55, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("warn_sticky", {31'd0, warn_signal}, 32'd1);
        checkOutput("j_after_warn", out, 32'd55);

        // Asynchronous reset clears the flag without waiting for an edge
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_warn", {31'd0, warn_signal}, 32'd0);
        checkOutput("reset_forces_out", out, 32'd0);

        // Reset wins over an invalid ID at a clock edge
        applyStimulus(32'd40, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_wins_warn", {31'd0, warn_signal}, 32'd0);
        applyStimulus(32'd21, 32'd100, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release_j", out, 32'd100);
        @(posedge clk);
        #1;
        checkOutput("release_warn", {31'd0, warn_signal}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
